// File: rtl/pose_sequencer.sv
// Pose recorder/replayer for a four-servo arm: captures live poses in IDLE and
// replays them in a loop, slewing each servo at most STEP per tick.
module pose_sequencer #(
   parameter int DEPTH      = 16,
   parameter int STEP       = 10,
   parameter int HOLD_TICKS = 20,
   parameter int RESET_POS  = 150
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_tick,
   input  logic        i_record,
   input  logic        i_play,
   input  logic        i_clear,
   input  logic [12:0] i_live0,
   input  logic [12:0] i_live1,
   input  logic [12:0] i_live2,
   input  logic [12:0] i_live3,
   output logic [12:0] o_servo0,
   output logic [12:0] o_servo1,
   output logic [12:0] o_servo2,
   output logic [12:0] o_servo3,
   output logic        o_replaying,
   output logic [4:0]  o_tot_state,
   output logic [4:0]  o_current_state,
   output logic        o_full
);

   typedef enum logic [1:0] {IDLE, MOVE, HOLD} state_t;

   localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              HW        = $clog2(HOLD_TICKS + 1);
   localparam logic [4:0]      DEPTH_C   = 5'(DEPTH);
   localparam logic [12:0]     STEP_C    = 13'(STEP);
   localparam logic [12:0]     RESET_C   = 13'(RESET_POS);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_TICKS - 1);

   state_t             state_q, state_d;
   logic [4:0]         tot_q, tot_d;
   logic [4:0]         cur_q, cur_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic               full_q, replaying_q;
   logic [12:0]        servo_q [4];
   logic [12:0]        servo_d [4];
   logic [12:0]        live    [4];
   logic [3:0][12:0]   mem     [DEPTH];
   logic [3:0][12:0]   target;
   logic               at_target;
   logic               wr_en;

   // Move one unsigned step toward tgt, clamping to tgt so it never overshoots.
   function automatic logic [12:0] step_toward(input logic [12:0] cur,
                                                input logic [12:0] tgt);
      logic [12:0] diff;
      if (cur < tgt) begin
         diff = tgt - cur;
         return (diff > STEP_C) ? cur + STEP_C : tgt;
      end else begin
         diff = cur - tgt;
         return (diff > STEP_C) ? cur - STEP_C : tgt;
      end
   endfunction

   assign live[0] = i_live0;
   assign live[1] = i_live1;
   assign live[2] = i_live2;
   assign live[3] = i_live3;

   // Pose store has no reset; o_tot_state alone decides which entries are valid.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[tot_q[AW-1:0]] <= {i_live3, i_live2, i_live1, i_live0};
   end

   assign target = mem[cur_q[AW-1:0]];

   always_comb begin
      at_target = 1'b1;
      for (int n = 0; n < 4; n++) begin
         if (servo_q[n] != target[n]) at_target = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      tot_d   = tot_q;
      cur_d   = cur_q;
      hold_d  = hold_q;
      wr_en   = 1'b0;
      for (int n = 0; n < 4; n++) servo_d[n] = servo_q[n];

      unique case (state_q)
         IDLE: begin
            for (int n = 0; n < 4; n++) servo_d[n] = live[n];
            if (i_clear) begin
               tot_d = '0;
            end else if (i_record) begin
               if (!full_q) begin
                  wr_en = 1'b1;
                  tot_d = tot_q + 5'd1;
               end
            end else if (i_play && (tot_q != 5'd0)) begin
               cur_d   = '0;
               hold_d  = '0;
               state_d = MOVE;
            end
         end
         MOVE: begin
            if (i_play) begin
               state_d = IDLE;
               cur_d   = '0;
               hold_d  = '0;
            end else if (at_target) begin
               state_d = HOLD;
               hold_d  = '0;
            end else if (i_tick) begin
               for (int n = 0; n < 4; n++) servo_d[n] = step_toward(servo_q[n], target[n]);
            end
         end
         HOLD: begin
            if (i_play) begin
               state_d = IDLE;
               cur_d   = '0;
               hold_d  = '0;
            end else if (i_tick) begin
               if (hold_q == HOLD_LAST) begin
                  hold_d  = '0;
                  state_d = MOVE;
                  cur_d   = (cur_q == tot_q - 5'd1) ? 5'd0 : cur_q + 5'd1;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tot_q       <= '0;
         cur_q       <= '0;
         hold_q      <= '0;
         full_q      <= 1'b0;
         replaying_q <= 1'b0;
         for (int n = 0; n < 4; n++) servo_q[n] <= RESET_C;
      end else begin
         tot_q       <= tot_d;
         cur_q       <= cur_d;
         hold_q      <= hold_d;
         full_q      <= (tot_d == DEPTH_C);
         replaying_q <= (state_d != IDLE);
         for (int n = 0; n < 4; n++) servo_q[n] <= servo_d[n];
      end
   end

   assign o_servo0        = servo_q[0];
   assign o_servo1        = servo_q[1];
   assign o_servo2        = servo_q[2];
   assign o_servo3        = servo_q[3];
   assign o_replaying     = replaying_q;
   assign o_tot_state     = tot_q;
   assign o_current_state = cur_q;
   assign o_full          = full_q;

endmodule
